// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Brief    : IF stage with loadable instruction memory, PC and IF/ID register,
//             gated by an IDLE/RUN/STEP/HALT control FSM.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch #(
    parameter int                  NB_DATA = 32,
    parameter int                  NB_ADDR = 8,
    parameter logic [NB_DATA-1:0]  HALT_OP = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic               i_step_mode,
    input  logic               i_step,
    input  logic               i_prog_we,
    input  logic [NB_ADDR-1:0] i_prog_addr,
    input  logic [NB_DATA-1:0] i_prog_data,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_pc_src,
    input  logic [NB_DATA-1:0] i_pc_target,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_DATA-1:0] o_pc_plus4,
    output logic [NB_DATA-1:0] o_pc,
    output logic               o_valid,
    output logic               o_halted
);

    localparam int                 c_DEPTH  = 2**NB_ADDR;
    localparam logic [NB_DATA-1:0] c_NOP    = '0;
    localparam logic [NB_DATA-1:0] c_PC_INC = NB_DATA'(4);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_STEP = 2'd2;
    localparam logic [1:0] c_HALT = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [NB_DATA-1:0] r_mem [c_DEPTH];
    logic [NB_DATA-1:0] r_pc;
    logic [NB_DATA-1:0] r_instruction;
    logic [NB_DATA-1:0] r_pc_plus4;
    logic               r_valid;
    logic [NB_DATA-1:0] w_fetch;
    logic [NB_DATA-1:0] w_pc_plus4;
    logic               w_advance;
    logic               w_prog_en;
    logic               w_halt_take;
    logic               w_halted;

    assign w_fetch    = r_mem[r_pc[NB_ADDR+1:2]];
    assign w_pc_plus4 = r_pc + c_PC_INC;
    // A halt word is only honoured when it is actually consumed, not when held or squashed by a redirect
    assign w_halt_take = w_advance && (w_fetch == HALT_OP) && !i_stall && !i_pc_src;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (i_run) w_state_next = i_step_mode ? c_STEP : c_RUN;
            c_RUN,
            c_STEP:  if (w_halt_take) w_state_next = c_HALT;
            default: w_state_next = c_HALT;
        endcase
    end

    always_comb begin
        w_advance = 1'b0;
        w_prog_en = 1'b0;
        w_halted  = 1'b0;
        case (r_state)
            c_IDLE:  w_prog_en = i_prog_we;
            c_RUN:   w_advance = 1'b1;
            c_STEP:  w_advance = i_step;
            default: w_halted  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_prog_en) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc          <= c_NOP;
            r_instruction <= c_NOP;
            r_pc_plus4    <= c_NOP;
            r_valid       <= 1'b0;
        end else if (w_advance) begin
            if (i_pc_src) begin
                r_pc <= i_pc_target;
            end else if (!i_stall && !w_halt_take) begin
                r_pc <= w_pc_plus4;
            end

            if (i_flush || (!i_stall && w_halt_take)) begin
                r_instruction <= c_NOP;
                r_pc_plus4    <= c_NOP;
                r_valid       <= 1'b0;
            end else if (!i_stall) begin
                r_instruction <= w_fetch;
                r_pc_plus4    <= w_pc_plus4;
                r_valid       <= 1'b1;
            end
        end
    end

    assign o_instruction = r_instruction;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_pc          = r_pc;
    assign o_valid       = r_valid;
    assign o_halted      = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Brief    : Directed bench for instruction_fetch with a behavioural fetch model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_run = 1'b0;
    logic        i_step_mode = 1'b0;
    logic        i_step = 1'b0;
    logic        i_prog_we = 1'b0;
    logic [7:0]  i_prog_addr = '0;
    logic [31:0] i_prog_data = '0;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_pc_src = 1'b0;
    logic [31:0] i_pc_target = '0;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        o_halted;

    int n_tests = 0;
    int n_fail  = 0;
    logic cmp_en = 1'b0;

    instruction_fetch dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_run        (i_run),
        .i_step_mode  (i_step_mode),
        .i_step       (i_step),
        .i_prog_we    (i_prog_we),
        .i_prog_addr  (i_prog_addr),
        .i_prog_data  (i_prog_data),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_pc_src     (i_pc_src),
        .i_pc_target  (i_pc_target),
        .o_instruction(o_instruction),
        .o_pc_plus4   (o_pc_plus4),
        .o_pc         (o_pc),
        .o_valid      (o_valid),
        .o_halted     (o_halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode flags, a word array and the IF/ID contents
    logic [31:0] m_mem [256];
    logic [31:0] m_pc = '0, m_ins = '0, m_p4 = '0;
    logic        m_valid = 1'b0, m_running = 1'b0, m_stepping = 1'b0, m_halted = 1'b0;
    logic [31:0] m_word;
    logic        m_idle, m_adv, m_hlt;

    assign m_word = m_mem[m_pc[9:2]];
    assign m_idle = !(m_running || m_stepping || m_halted);
    assign m_adv  = m_running || (m_stepping && i_step);
    assign m_hlt  = m_adv && (m_word == 32'hFFFF_FFFF) && !i_stall && !i_pc_src;

    always @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            m_pc <= '0; m_ins <= '0; m_p4 <= '0; m_valid <= 1'b0;
            m_running <= 1'b0; m_stepping <= 1'b0; m_halted <= 1'b0;
        end else begin
            if (m_idle) begin
                if (i_prog_we) m_mem[i_prog_addr] <= i_prog_data;
                if (i_run) begin
                    m_running  <= !i_step_mode;
                    m_stepping <= i_step_mode;
                end
            end
            if (m_adv) begin
                m_pc <= i_pc_src ? i_pc_target : ((i_stall || m_hlt) ? m_pc : m_pc + 32'd4);
                if (i_flush || (!i_stall && m_hlt)) begin
                    m_ins <= '0; m_p4 <= '0; m_valid <= 1'b0;
                end else if (!i_stall) begin
                    m_ins <= m_word; m_p4 <= m_pc + 32'd4; m_valid <= 1'b1;
                end
                if (m_hlt) begin
                    m_running <= 1'b0; m_stepping <= 1'b0; m_halted <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", o_pc, m_pc);
            chk("instruction", o_instruction, m_ins);
            chk("valid", 32'(o_valid), 32'(m_valid));
            chk("halted", 32'(o_halted), 32'(m_halted));
            if (m_valid) chk("pc_plus4", o_pc_plus4, m_p4);
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        i_prog_we   = 1'b1;
        i_prog_addr = a[7:0];
        i_prog_data = d;
        tick();
        i_prog_we   = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        i_rst  = 1'b0;
        cmp_en = 1'b1;
        chk("reset_pc", o_pc, 32'h0);
        chk("reset_instr", o_instruction, 32'h0);
        chk("reset_valid", 32'(o_valid), 32'h0);
        chk("reset_halted", 32'(o_halted), 32'h0);

        for (int i = 0; i < 256; i++) load(i, 32'h0800_0000 | i);
        load(0, 32'h2001_0005);
        load(1, 32'h2002_0003);
        load(2, 32'h0022_1820);
        load(3, 32'hFFFF_FFFF);

        // Straight-line program ending in halt
        i_run = 1'b1;
        tick();
        chk("t1_pc_start", o_pc, 32'h0);
        tick();
        chk("t1_ins0", o_instruction, 32'h2001_0005);
        chk("t1_p4_0", o_pc_plus4, 32'd4);
        tick();
        chk("t1_ins1", o_instruction, 32'h2002_0003);
        chk("t1_p4_1", o_pc_plus4, 32'd8);
        tick();
        chk("t1_ins2", o_instruction, 32'h0022_1820);
        chk("t1_p4_2", o_pc_plus4, 32'd12);
        tick();
        chk("t1_halt_valid", 32'(o_valid), 32'h0);
        chk("t1_halted", 32'(o_halted), 32'h1);
        chk("t1_halt_pc", o_pc, 32'd12);
        tick();
        tick();
        chk("t1_halt_pc_hold", o_pc, 32'd12);

        // Stall at PC=8
        do_reset();
        tick(); tick(); tick();
        chk("t2_pc8", o_pc, 32'd8);
        i_stall = 1'b1;
        tick();
        chk("t2_stall_pc", o_pc, 32'd8);
        chk("t2_stall_ins", o_instruction, 32'h2002_0003);
        tick();
        chk("t2_stall_ins2", o_instruction, 32'h2002_0003);
        i_stall = 1'b0;
        tick();
        chk("t2_resume_ins", o_instruction, 32'h0022_1820);
        tick(); tick();

        // Redirect with flush, then halt suppression by stall / redirect
        do_reset();
        tick(); tick(); tick();
        i_pc_src = 1'b1; i_pc_target = 32'h40; i_flush = 1'b1;
        tick();
        chk("t3_redir_pc", o_pc, 32'h40);
        chk("t3_flush_valid", 32'(o_valid), 32'h0);
        i_pc_src = 1'b0; i_flush = 1'b0;
        tick();
        chk("t3_target_ins", o_instruction, 32'h0800_0010);
        chk("t3_target_p4", o_pc_plus4, 32'h44);
        i_pc_src = 1'b1; i_pc_target = 32'hC;
        tick();
        i_pc_src = 1'b0; i_stall = 1'b1;
        tick();
        chk("t3_stall_no_halt", 32'(o_halted), 32'h0);
        i_stall = 1'b0; i_pc_src = 1'b1; i_pc_target = 32'h0;
        tick();
        chk("t3_redir_no_halt", 32'(o_halted), 32'h0);
        chk("t3_spec_halt_word", o_instruction, 32'hFFFF_FFFF);
        i_pc_src = 1'b1; i_pc_target = 32'hFFFF_FFFC;
        tick();
        i_pc_src = 1'b0;
        tick();
        chk("t3_wrap_ins", o_instruction, 32'h0800_00FF);
        chk("t3_wrap_p4", o_pc_plus4, 32'h0);
        chk("t3_wrap_pc", o_pc, 32'h0);
        i_pc_src = 1'b1; i_pc_target = 32'h400;
        tick();
        i_pc_src = 1'b0;
        tick();
        chk("t3_addr_trunc_ins", o_instruction, 32'h2001_0005);

        // Step mode
        i_step_mode = 1'b1;
        do_reset();
        tick();
        repeat (5) tick();
        chk("t4_no_step_pc", o_pc, 32'h0);
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        chk("t4_step_pc", o_pc, 32'd4);
        chk("t4_step_ins", o_instruction, 32'h2001_0005);
        tick();
        chk("t4_step_hold", o_pc, 32'd4);

        // Asynchronous reset mid-run at PC=0x10
        i_step_mode = 1'b0;
        do_reset();
        tick(); tick();
        i_pc_src = 1'b1; i_pc_target = 32'h10;
        tick();
        i_pc_src = 1'b0;
        chk("t5_pc10", o_pc, 32'h10);
        #2 i_rst = 1'b1;
        #1;
        chk("t5_async_pc", o_pc, 32'h0);
        chk("t5_async_ins", o_instruction, 32'h0);
        chk("t5_async_valid", 32'(o_valid), 32'h0);
        tick();
        i_rst = 1'b0;
        tick(); tick();
        chk("t5_mem_kept", o_instruction, 32'h2001_0005);

        // Program write ignored while running, honoured in IDLE
        i_prog_we = 1'b1; i_prog_addr = 8'd2; i_prog_data = 32'h1234_5678;
        tick();
        i_prog_we = 1'b0;
        tick();
        chk("t6_run_write_ignored", o_instruction, 32'h0022_1820);
        tick(); tick();
        i_run = 1'b0;
        do_reset();
        load(2, 32'h1234_5678);
        i_run = 1'b1;
        tick(); tick(); tick(); tick();
        chk("t6_idle_write", o_instruction, 32'h1234_5678);
        tick(); tick();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
